// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite line mixer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sprite_pkg;

    localparam int NUM_LAYERS_DEF = 4;
    localparam int LINE_PIX_DEF   = 16;
    localparam int IDX_W_DEF      = 5;
    localparam int COLOR_W_DEF    = 24;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Index width that stays at least 1 bit wide for single-entry ranges.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_line_mixer_if.sv
// Line-in / pixel-out bundle of the sprite line mixer.
// Latency: n/a (wires only).
// Backpressure: line_valid/line_ready handshake on the segment side; pixel side has no backpressure.
// Ports: layer_mask, layer_idx, line_valid (source -> mixer); line_ready, pix_valid, pix_color, pix_blank (mixer -> sink).
interface sprite_line_mixer_if
    import sprite_pkg::*;
#(
    parameter int NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int LINE_PIX   = LINE_PIX_DEF,
    parameter int IDX_W      = IDX_W_DEF,
    parameter int COLOR_W    = COLOR_W_DEF
);
    logic [NUM_LAYERS*LINE_PIX-1:0] layer_mask;
    logic [NUM_LAYERS*IDX_W-1:0]    layer_idx;
    logic                           line_valid;
    logic                           line_ready;
    logic                           pix_valid;
    logic [COLOR_W-1:0]             pix_color;
    logic                           pix_blank;

    modport master (
        output layer_mask, layer_idx, line_valid,
        input  line_ready, pix_valid, pix_color, pix_blank
    );

    modport slave (
        input  layer_mask, layer_idx, line_valid,
        output line_ready, pix_valid, pix_color, pix_blank
    );
endinterface

// File: rtl/sprite_prio_enc.sv
// Priority encoder: picks the lowest-numbered asserted request.
// Latency: combinational.
// Backpressure: none.
// Ports: i_req (request vector), o_hit (any request), o_layer (winning index, 0 when no hit).
module sprite_prio_enc
    import sprite_pkg::*;
#(
    parameter int NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int LAYER_W    = clog2_min1(NUM_LAYERS)
)(
    input  logic [NUM_LAYERS-1:0] i_req,
    output logic                  o_hit,
    output logic [LAYER_W-1:0]    o_layer
);
    always_comb begin
        o_hit   = |i_req;
        o_layer = '0;
        // Walk from the top down so the lowest set index is written last and wins.
        for (int n = NUM_LAYERS - 1; n >= 0; n--) begin
            if (i_req[n]) begin
                o_layer = LAYER_W'(n);
            end
        end
    end
endmodule

// File: rtl/sprite_line_mixer.sv
// Sprite line mixer: double-buffered segments, per-pixel layer priority, palette lookup.
// Latency: accept to first pixel 2 edges; one registered pixel per cycle, back-to-back segments gapless.
// Backpressure: line_ready drops while the shadow buffer holds a segment; pixel output cannot stall.
// Ports: clock_25, rst (async active-low), bus (line in / pixel out), layer_en, pal_we/pal_addr/pal_data, bg_color, flush.
module sprite_line_mixer
    import sprite_pkg::*;
#(
    parameter int NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int LINE_PIX   = LINE_PIX_DEF,
    parameter int IDX_W      = IDX_W_DEF,
    parameter int COLOR_W    = COLOR_W_DEF
)(
    input  logic                  clock_25,
    input  logic                  rst,
    sprite_line_mixer_if.slave    bus,
    input  logic [NUM_LAYERS-1:0] layer_en,
    input  logic                  pal_we,
    input  logic [IDX_W-1:0]      pal_addr,
    input  logic [COLOR_W-1:0]    pal_data,
    input  logic [COLOR_W-1:0]    bg_color,
    input  logic                  flush
);
    localparam int LAYER_W = clog2_min1(NUM_LAYERS);
    localparam int K_W     = clog2_min1(LINE_PIX);
    localparam logic [K_W-1:0] K_LAST = K_W'(LINE_PIX - 1);

    state_t                         r_state;
    logic [K_W-1:0]                 r_k;
    logic                           r_shd_full;
    logic [NUM_LAYERS*LINE_PIX-1:0] r_shd_mask;
    logic [NUM_LAYERS*IDX_W-1:0]    r_shd_idx;
    logic [NUM_LAYERS*LINE_PIX-1:0] r_act_mask;
    logic [NUM_LAYERS*IDX_W-1:0]    r_act_idx;
    logic [COLOR_W-1:0]             r_pal [2**IDX_W];
    logic                           r_pix_valid;
    logic [COLOR_W-1:0]             r_pix_color;
    logic                           r_pix_blank;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_xfer;
    logic [K_W-1:0]        w_bitsel;
    logic [NUM_LAYERS-1:0] w_req;
    logic [IDX_W-1:0]      w_idx_arr [NUM_LAYERS];
    logic                  w_hit;
    logic [LAYER_W-1:0]    w_layer;
    logic [IDX_W-1:0]      w_idx;
    logic [COLOR_W-1:0]    w_pal_rd;

    assign bus.line_ready = rst & ~r_shd_full;
    assign bus.pix_valid  = r_pix_valid;
    assign bus.pix_color  = r_pix_color;
    assign bus.pix_blank  = r_pix_blank;

    // Flush wins over a same-edge accept: the offered segment is dropped.
    assign w_accept = bus.line_valid & bus.line_ready & ~flush;
    assign w_last   = (r_k == K_LAST);
    // Shadow moves to active when idle, or on the last pixel so the next line starts without a bubble.
    assign w_xfer   = r_shd_full & ((r_state == ST_IDLE) | ((r_state == ST_EMIT) & w_last));
    // Pixel 0 is the MSB of each layer's mask slice.
    assign w_bitsel = K_LAST - r_k;

    for (genvar n = 0; n < NUM_LAYERS; n++) begin : g_layer
        logic [LINE_PIX-1:0] w_lmask;
        assign w_lmask      = r_act_mask[n*LINE_PIX +: LINE_PIX];
        assign w_req[n]     = w_lmask[w_bitsel] & layer_en[n];
        assign w_idx_arr[n] = r_act_idx[n*IDX_W +: IDX_W];
    end

    sprite_prio_enc #(
        .NUM_LAYERS (NUM_LAYERS),
        .LAYER_W    (LAYER_W)
    ) u_prio (
        .i_req   (w_req),
        .o_hit   (w_hit),
        .o_layer (w_layer)
    );

    assign w_idx    = w_idx_arr[w_layer];
    // Read before the same-edge write lands, so a write to the pixel's entry shows up from the next pixel.
    assign w_pal_rd = r_pal[w_idx];

    // Palette is intentionally left out of reset.
    always_ff @(posedge clock_25) begin
        if (pal_we) begin
            r_pal[pal_addr] <= pal_data;
        end
    end

    always_ff @(posedge clock_25 or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_shd_full  <= 1'b0;
            r_shd_mask  <= '0;
            r_shd_idx   <= '0;
            r_act_mask  <= '0;
            r_act_idx   <= '0;
            r_pix_valid <= 1'b0;
            r_pix_color <= '0;
            r_pix_blank <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_shd_full  <= 1'b0;
            r_act_mask  <= '0;
            r_act_idx   <= '0;
            r_pix_valid <= 1'b0;
            r_pix_color <= '0;
            r_pix_blank <= 1'b0;
        end else begin
            if (r_state == ST_EMIT) begin
                r_pix_valid <= 1'b1;
                r_pix_color <= w_hit ? w_pal_rd : bg_color;
                r_pix_blank <= ~w_hit;
            end else begin
                r_pix_valid <= 1'b0;
                r_pix_color <= '0;
                r_pix_blank <= 1'b0;
            end

            // On a coincident accept and transfer the old shadow goes to active and the new one is loaded.
            if (w_accept) begin
                r_shd_full <= 1'b1;
                r_shd_mask <= bus.layer_mask;
                r_shd_idx  <= bus.layer_idx;
            end else if (w_xfer) begin
                r_shd_full <= 1'b0;
            end

            if (w_xfer) begin
                r_act_mask <= r_shd_mask;
                r_act_idx  <= r_shd_idx;
                r_k        <= '0;
                r_state    <= ST_EMIT;
            end else if (r_state == ST_EMIT) begin
                if (w_last) begin
                    r_k     <= '0;
                    r_state <= ST_IDLE;
                end else begin
                    r_k <= r_k + K_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_sprite_line_mixer.sv
// Directed bench for sprite_line_mixer with hand-computed pixel expectations.
// Latency: n/a.
// Backpressure: segments are offered and held until line_ready is seen.
module tb_sprite_line_mixer;
    import sprite_pkg::*;

    localparam int NL = 4;
    localparam int LP = 16;
    localparam int IW = 5;
    localparam int CW = 24;
    localparam logic [CW-1:0] BG = 24'h0A0B0C;

    logic          clock_25 = 1'b0;
    logic          rst      = 1'b0;
    logic [NL-1:0] layer_en;
    logic          pal_we;
    logic [IW-1:0] pal_addr;
    logic [CW-1:0] pal_data;
    logic [CW-1:0] bg_color;
    logic          flush;

    int n_vec = 0;
    int n_err = 0;

    sprite_line_mixer_if #(.NUM_LAYERS(NL), .LINE_PIX(LP), .IDX_W(IW), .COLOR_W(CW)) bus ();

    sprite_line_mixer #(.NUM_LAYERS(NL), .LINE_PIX(LP), .IDX_W(IW), .COLOR_W(CW)) dut (
        .clock_25 (clock_25),
        .rst      (rst),
        .bus      (bus),
        .layer_en (layer_en),
        .pal_we   (pal_we),
        .pal_addr (pal_addr),
        .pal_data (pal_data),
        .bg_color (bg_color),
        .flush    (flush)
    );

    always #20 clock_25 = ~clock_25;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_25);
        #1;
    endtask

    task automatic pal_write(input logic [IW-1:0] a, input logic [CW-1:0] d);
        pal_we   = 1'b1;
        pal_addr = a;
        pal_data = d;
        tick();
        pal_we   = 1'b0;
    endtask

    // Holds a segment on the bus until it is taken; returns just after the accepting edge.
    task automatic offer(input logic [NL*LP-1:0] m, input logic [NL*IW-1:0] x);
        bit done;
        done = 1'b0;
        bus.layer_mask = m;
        bus.layer_idx  = x;
        bus.line_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            done = bus.line_ready;
            tick();
        end
        bus.line_valid = 1'b0;
        chk("offer_accepted", 32'(done), 1);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        flush = 1'b0; pal_we = 1'b0; pal_addr = '0; pal_data = '0;
        bg_color = BG; layer_en = '1;
        bus.line_valid = 1'b0; bus.layer_mask = '0; bus.layer_idx = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_valid", 32'(bus.pix_valid), 0);
        chk("rst_color", 32'(bus.pix_color), 0);
        chk("rst_blank", 32'(bus.pix_blank), 0);
        chk("rst_ready", 32'(bus.line_ready), 0);
        rst = 1'b1;
        #1;
        chk("rel_ready", 32'(bus.line_ready), 1);
        tick();

        pal_write(5'd3, 24'hFF0000);
        pal_write(5'd1, 24'h00FF00);
        pal_write(5'd5, 24'h0000FF);
        pal_write(5'd7, 24'h123456);

        // Single hit at pixel 0, everything else background
        offer({16'h0, 16'h0, 16'h0, 16'h8000}, {5'd0, 5'd0, 5'd0, 5'd3});
        chk("t1_rdy_full", 32'(bus.line_ready), 0);
        tick();
        chk("t1_latency", 32'(bus.pix_valid), 0);
        for (int k = 0; k < LP; k++) begin
            tick();
            chk($sformatf("t1_valid[%0d]", k), 32'(bus.pix_valid), 1);
            chk($sformatf("t1_color[%0d]", k), 32'(bus.pix_color), (k == 0) ? 32'hFF0000 : 32'(BG));
            chk($sformatf("t1_blank[%0d]", k), 32'(bus.pix_blank), (k == 0) ? 0 : 1);
        end
        tick();
        chk("t1_end_valid", 32'(bus.pix_valid), 0);
        chk("t1_end_color", 32'(bus.pix_color), 0);
        chk("t1_end_blank", 32'(bus.pix_blank), 0);

        // Priority with layer 0 disabled: p2 -> layer1 (idx1), p5 -> layer2 (idx5), p0 -> bg
        layer_en = 4'b1110;
        offer({16'h0, 16'h0400, 16'h2000, 16'h8400}, {5'd0, 5'd5, 5'd1, 5'd3});
        tick();
        for (int k = 0; k < LP; k++) begin
            tick();
            chk($sformatf("t2_color[%0d]", k), 32'(bus.pix_color),
                (k == 2) ? 32'h00FF00 : (k == 5) ? 32'h0000FF : 32'(BG));
            chk($sformatf("t2_blank[%0d]", k), 32'(bus.pix_blank), (k == 2 || k == 5) ? 0 : 1);
        end
        tick();
        layer_en = '1;

        // Back-to-back segments: 32 gapless pixels
        chk("t3_rdy0", 32'(bus.line_ready), 1);
        bus.layer_mask = {48'h0, 16'hFFFF};
        bus.layer_idx  = {15'd0, 5'd3};
        bus.line_valid = 1'b1;
        tick();
        chk("t3_rdy_full_a", 32'(bus.line_ready), 0);
        bus.layer_mask = {32'h0, 16'hFFFF, 16'h0};
        bus.layer_idx  = {10'd0, 5'd1, 5'd0};
        tick();
        chk("t3_rdy_free", 32'(bus.line_ready), 1);
        tick();
        bus.line_valid = 1'b0;
        chk("t3_rdy_full_b", 32'(bus.line_ready), 0);
        chk("t3_valid[0]", 32'(bus.pix_valid), 1);
        chk("t3_color[0]", 32'(bus.pix_color), 32'hFF0000);
        for (int i = 1; i < 2*LP; i++) begin
            tick();
            chk($sformatf("t3_valid[%0d]", i), 32'(bus.pix_valid), 1);
            chk($sformatf("t3_color[%0d]", i), 32'(bus.pix_color), (i < LP) ? 32'hFF0000 : 32'h00FF00);
            chk($sformatf("t3_ready[%0d]", i), 32'(bus.line_ready), (i >= LP-1) ? 1 : 0);
        end
        tick();
        chk("t3_end_valid", 32'(bus.pix_valid), 0);

        // Palette rewrite of the in-use entry during pixel 7
        offer({48'h0, 16'hFFFF}, {15'd0, 5'd7});
        tick();
        for (int j = 0; j < LP; j++) begin
            if (j == 7) begin
                pal_we = 1'b1; pal_addr = 5'd7; pal_data = 24'hABCDEF;
            end
            tick();
            pal_we = 1'b0;
            chk($sformatf("t4_color[%0d]", j), 32'(bus.pix_color), (j <= 7) ? 32'h123456 : 32'hABCDEF);
        end
        tick();

        // Flush at pixel 9 together with a new offer
        offer({48'h0, 16'hFFFF}, {15'd0, 5'd3});
        tick();
        for (int j = 0; j < 9; j++) begin
            tick();
            chk($sformatf("t5_valid[%0d]", j), 32'(bus.pix_valid), 1);
        end
        chk("t5_rdy_pre", 32'(bus.line_ready), 1);
        flush = 1'b1;
        bus.layer_mask = {32'h0, 16'hFFFF, 16'h0};
        bus.layer_idx  = {10'd0, 5'd1, 5'd0};
        bus.line_valid = 1'b1;
        tick();
        flush = 1'b0;
        bus.line_valid = 1'b0;
        chk("t5_valid_off", 32'(bus.pix_valid), 0);
        chk("t5_color_off", 32'(bus.pix_color), 0);
        chk("t5_blank_off", 32'(bus.pix_blank), 0);
        chk("t5_ready", 32'(bus.line_ready), 1);
        chk("t5_state", 32'(dut.r_state), 32'(ST_IDLE));
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("t5_dropped[%0d]", j), 32'(bus.pix_valid), 0);
        end

        // Asynchronous reset mid-line
        offer({48'h0, 16'hFFFF}, {15'd0, 5'd3});
        tick();
        for (int j = 0; j < 5; j++) tick();
        chk("t6_mid_valid", 32'(bus.pix_valid), 1);
        rst = 1'b0;
        #1;
        chk("t6_async_valid", 32'(bus.pix_valid), 0);
        chk("t6_async_color", 32'(bus.pix_color), 0);
        chk("t6_async_blank", 32'(bus.pix_blank), 0);
        chk("t6_async_ready", 32'(bus.line_ready), 0);
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rel_ready", 32'(bus.line_ready), 1);
        tick();
        chk("t6_abandon_valid", 32'(bus.pix_valid), 0);
        chk("t6_abandon_ready", 32'(bus.line_ready), 1);

        // Palette survives reset
        offer({48'h0, 16'hFFFF}, {15'd0, 5'd3});
        tick();
        tick();
        chk("t6_pal_kept", 32'(bus.pix_color), 32'hFF0000);
        repeat (LP + 2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
